// File: rtl/instruction_fetch_queue.sv
// rtl/instruction_fetch_queue.sv - prefetching fetch stage with {pc, instr} queue
module instruction_fetch_queue #(
    parameter int PC_WIDTH         = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int CACHE_ADDR_WIDTH = 16,
    parameter int DEPTH            = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          DIR,
    input  logic [PC_WIDTH-1:0]           data_in,
    output logic                          ack_prev,
    output logic                          DOR,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic [PC_WIDTH-1:0]           pc_out,
    input  logic                          ack_from_next,
    output logic                          cache_en,
    output logic [CACHE_ADDR_WIDTH-1:0]   cache_addr,
    input  logic [DATA_WIDTH-1:0]         cache_do,
    input  logic                          cache_do_ack,
    output logic [$clog2(DEPTH):0]        occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, STALL, DRAIN} state_t;

    state_t                 state;
    logic [PC_WIDTH-1:0]    fetch_pc;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [PC_WIDTH-1:0]    pc_mem   [DEPTH];
    logic [DATA_WIDTH-1:0]  data_mem [DEPTH];

    logic                   accept;
    logic                   push;
    logic                   pop;
    logic [OW-1:0]          occ_next;
    logic [PW-1:0]          rd_next;
    logic                   room_next;
    logic [PC_WIDTH-1:0]    new_pc;
    logic [PC_WIDTH-1:0]    pc_plus4;
    logic [PC_WIDTH-1:0]    head_pc;
    logic [DATA_WIDTH-1:0]  head_data;

    function automatic logic [CACHE_ADDR_WIDTH-1:0] word_addr(input logic [PC_WIDTH-1:0] pc);
        return pc[CACHE_ADDR_WIDTH+1:2];
    endfunction

    always_comb begin
        accept    = DIR && !ack_prev;
        // A redirect flushes the queue, so it overrides both the pop and the push.
        pop       = DOR && ack_from_next && !accept;
        push      = (state == REQ) && cache_do_ack && !accept;
        occ_next  = occupancy + OW'(push) - OW'(pop);
        rd_next   = rd_ptr + PW'(pop);
        room_next = occ_next < OW'(DEPTH);
        new_pc    = {data_in[PC_WIDTH-1:2], 2'b00};
        pc_plus4  = fetch_pc + PC_WIDTH'(4);
        // When the queue is empty after this cycle's pop, the new head is the word being pushed.
        if (push && (occupancy - OW'(pop)) == '0) begin
            head_pc   = fetch_pc;
            head_data = cache_do;
        end else begin
            head_pc   = pc_mem[rd_next];
            head_data = data_mem[rd_next];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= fetch_pc;
            data_mem[wr_ptr] <= cache_do;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            fetch_pc   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occupancy  <= '0;
            ack_prev   <= 1'b0;
            DOR        <= 1'b0;
            data_out   <= '0;
            pc_out     <= '0;
            cache_en   <= 1'b0;
            cache_addr <= '0;
        end else begin
            ack_prev <= accept;
            if (accept) begin
                fetch_pc  <= new_pc;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                occupancy <= '0;
                DOR       <= 1'b0;
                data_out  <= '0;
                pc_out    <= '0;
                // An outstanding request cannot be withdrawn; its data is drained first.
                if ((state == REQ || state == DRAIN) && !cache_do_ack) begin
                    state <= DRAIN;
                end else begin
                    state      <= REQ;
                    cache_en   <= 1'b1;
                    cache_addr <= word_addr(new_pc);
                end
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                rd_ptr    <= rd_next;
                occupancy <= occ_next;
                DOR       <= occ_next != '0;
                if (occ_next != '0) begin
                    data_out <= head_data;
                    pc_out   <= head_pc;
                end
                case (state)
                    REQ: begin
                        if (cache_do_ack) begin
                            fetch_pc <= pc_plus4;
                            if (room_next) begin
                                cache_addr <= word_addr(pc_plus4);
                            end else begin
                                state    <= STALL;
                                cache_en <= 1'b0;
                            end
                        end
                    end
                    STALL: begin
                        if (room_next) begin
                            state      <= REQ;
                            cache_en   <= 1'b1;
                            cache_addr <= word_addr(fetch_pc);
                        end
                    end
                    DRAIN: begin
                        if (cache_do_ack) begin
                            state      <= REQ;
                            cache_addr <= word_addr(fetch_pc);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb/tb_instruction_fetch_queue.sv - directed bench for instruction_fetch_queue
module tb_instruction_fetch_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic        DIR;
    logic [31:0] data_in;
    logic        ack_prev;
    logic        DOR;
    logic [31:0] data_out;
    logic [31:0] pc_out;
    logic        ack_from_next;
    logic        cache_en;
    logic [15:0] cache_addr;
    logic [31:0] cache_do;
    logic        cache_do_ack;
    logic [2:0]  occupancy;

    int tests = 0;
    int fails = 0;

    instruction_fetch_queue dut (
        .clk           (clk),
        .reset         (reset),
        .DIR           (DIR),
        .data_in       (data_in),
        .ack_prev      (ack_prev),
        .DOR           (DOR),
        .data_out      (data_out),
        .pc_out        (pc_out),
        .ack_from_next (ack_from_next),
        .cache_en      (cache_en),
        .cache_addr    (cache_addr),
        .cache_do      (cache_do),
        .cache_do_ack  (cache_do_ack),
        .occupancy     (occupancy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ack(input logic [31:0] d);
        cache_do_ack = 1'b1;
        cache_do     = d;
        step();
        cache_do_ack = 1'b0;
        cache_do     = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        DIR     = 1'b1;
        data_in = pc;
        step();
        DIR     = 1'b0;
    endtask

    initial begin
        reset = 1'b1; DIR = 1'b0; data_in = '0; ack_from_next = 1'b0;
        cache_do = '0; cache_do_ack = 1'b0;

        // Reset state
        do_reset();
        chk("rst_cache_en", 32'(cache_en), 0);
        chk("rst_dor", 32'(DOR), 0);
        chk("rst_ack_prev", 32'(ack_prev), 0);
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_data_out", data_out, 0);

        // Sequential fetch with decode always consuming
        ack_from_next = 1'b1;
        redirect(32'h103);
        chk("t1_ack_prev", 32'(ack_prev), 1);
        chk("t1_en0", 32'(cache_en), 1);
        chk("t1_addr0", 32'(cache_addr), 32'h40);
        ack(32'hA0);
        chk("t1_ack_prev_pulse", 32'(ack_prev), 0);
        chk("t1_dor", 32'(DOR), 1);
        chk("t1_pc0", pc_out, 32'h100);
        chk("t1_d0", data_out, 32'hA0);
        chk("t1_addr1", 32'(cache_addr), 32'h41);
        ack(32'hA1);
        chk("t1_occ_pushpop", 32'(occupancy), 1);
        chk("t1_pc1", pc_out, 32'h104);
        chk("t1_d1", data_out, 32'hA1);
        ack(32'hA2);
        chk("t1_pc2", pc_out, 32'h108);
        chk("t1_d2", data_out, 32'hA2);
        chk("t1_addr3", 32'(cache_addr), 32'h43);

        // Fill to DEPTH, stall, resume on a pop
        do_reset();
        ack_from_next = 1'b0;
        redirect(32'h100);
        ack(32'hA0);
        ack(32'hA1);
        ack(32'hA2);
        chk("t2_en_before_full", 32'(cache_en), 1);
        ack(32'hA3);
        chk("t2_stall_en", 32'(cache_en), 0);
        chk("t2_full_occ", 32'(occupancy), 4);
        chk("t2_full_dor", 32'(DOR), 1);
        chk("t2_head_pc", pc_out, 32'h100);
        step();
        chk("t2_still_stalled", 32'(cache_en), 0);
        ack_from_next = 1'b1;
        step();
        ack_from_next = 1'b0;
        chk("t2_resume_en", 32'(cache_en), 1);
        chk("t2_resume_addr", 32'(cache_addr), 32'h44);
        chk("t2_occ_after_pop", 32'(occupancy), 3);
        chk("t2_pc_after_pop", pc_out, 32'h104);

        // Pop coincident with cache_do_ack at occupancy 2
        ack_from_next = 1'b1;
        step();
        chk("t4_occ2", 32'(occupancy), 2);
        chk("t4_pc_108", pc_out, 32'h108);
        ack(32'hA4);
        chk("t4_occ_same", 32'(occupancy), 2);
        chk("t4_pc_10c", pc_out, 32'h10C);
        chk("t4_d_a3", data_out, 32'hA3);
        step();
        ack_from_next = 1'b0;
        chk("t4_pc_110", pc_out, 32'h110);
        chk("t4_d_a4", data_out, 32'hA4);
        chk("t4_occ1", 32'(occupancy), 1);

        // Redirect with a request outstanding drains the old request
        do_reset();
        redirect(32'h100);
        ack(32'hA0);
        ack(32'hA1);
        chk("t3_occ_before", 32'(occupancy), 2);
        redirect(32'h200);
        chk("t3_flush_dor", 32'(DOR), 0);
        chk("t3_flush_occ", 32'(occupancy), 0);
        chk("t3_drain_en", 32'(cache_en), 1);
        chk("t3_drain_addr", 32'(cache_addr), 32'h42);
        step();
        chk("t3_drain_hold", 32'(cache_addr), 32'h42);
        ack(32'hBAD);
        chk("t3_new_addr", 32'(cache_addr), 32'h80);
        chk("t3_discard_dor", 32'(DOR), 0);
        chk("t3_discard_occ", 32'(occupancy), 0);
        ack(32'hC0);
        chk("t3_first_pc", pc_out, 32'h200);
        chk("t3_first_d", data_out, 32'hC0);

        // Redirect, pop and cache_do_ack all in one cycle; DIR held while ack_prev=1
        DIR = 1'b1; data_in = 32'h300; ack_from_next = 1'b1;
        ack(32'hDD);
        ack_from_next = 1'b0;
        data_in = 32'h400;
        chk("t3b_ack_prev", 32'(ack_prev), 1);
        chk("t3b_occ", 32'(occupancy), 0);
        chk("t3b_dor", 32'(DOR), 0);
        chk("t3b_addr", 32'(cache_addr), 32'hC0);
        step();
        DIR = 1'b0;
        chk("t3b_dir_ignored", 32'(ack_prev), 0);
        chk("t3b_addr_kept", 32'(cache_addr), 32'hC0);

        // Reset mid-request; late ack ignored
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_en", 32'(cache_en), 0);
        chk("t5_dor", 32'(DOR), 0);
        chk("t5_ack_prev", 32'(ack_prev), 0);
        chk("t5_occ", 32'(occupancy), 0);
        ack(32'hEE);
        chk("t5_late_occ", 32'(occupancy), 0);
        chk("t5_late_dor", 32'(DOR), 0);
        chk("t5_late_en", 32'(cache_en), 0);

        // PC wrap
        ack_from_next = 1'b1;
        redirect(32'hFFFF_FFFC);
        chk("t6_addr_top", 32'(cache_addr), 32'hFFFF);
        ack(32'hE0);
        chk("t6_pc_top", pc_out, 32'hFFFF_FFFC);
        chk("t6_d_top", data_out, 32'hE0);
        chk("t6_addr_wrap", 32'(cache_addr), 32'h0);
        ack(32'hE1);
        chk("t6_pc_wrap", pc_out, 32'h0);
        chk("t6_d_wrap", data_out, 32'hE1);
        chk("t6_addr_next", 32'(cache_addr), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
